// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, owner codes
// and the width of the read-latency wait counter.
package mem_arb_pkg;

   localparam int LAT_W = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_DATA  = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-macro signals around the arbiter.
// slave: the arbiter's view. master: the surrounding core and memory.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_valid;
   logic [DATA_W-1:0] if_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_valid;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection between fetch and data requests.
// MEM_ARB_ROUND_ROBIN_EN: ties go to the requester that was not the last
// owner; otherwise data always beats fetch and last_owner is ignored.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic   if_req,
   input  logic   d_req,
   input  owner_t last_owner,
   output logic   grant_valid,
   output owner_t winner
);

   assign grant_valid = if_req | d_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // Alternate on a tie, otherwise the lone requester wins.
   always_comb begin
      winner = OWN_FETCH;
      if (if_req && d_req)
         winner = (last_owner == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
      else if (d_req)
         winner = OWN_DATA;
   end
`else
   logic unused_last_owner;
   assign unused_last_owner = last_owner;

   // Data path has fixed priority over fetch.
   always_comb begin
      winner = OWN_FETCH;
      if (d_req)
         winner = OWN_DATA;
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the multicycle core: one access at a time,
// waits out MEM_LAT read cycles, returns data or a store acknowledgement.
// Tie policy selectable with MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input logic              clock,
   input logic              reset,
   mem_port_arbiter_if.slave bus
);

   state_t            state;
   state_t            state_nx;
   owner_t            owner;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [LAT_W-1:0]  cnt;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              grant_valid;
   owner_t            winner;
   logic              is_store;

   mem_arb_pick u_pick (
      .if_req      (bus.if_req),
      .d_req       (bus.d_req),
      .last_owner  (owner),
      .grant_valid (grant_valid),
      .winner      (winner)
   );

   assign is_store      = (owner == OWN_DATA) && we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Next-state and Moore outputs; all outputs decode from state so reset clears them at once.
   always_comb begin
      state_nx     = state;
      bus.mem_en   = 1'b0;
      bus.mem_we   = 1'b0;
      bus.if_gnt   = 1'b0;
      bus.d_gnt    = 1'b0;
      bus.if_valid = 1'b0;
      bus.d_valid  = 1'b0;
      bus.busy     = (state != IDLE);
      case (state)
         IDLE: begin
            if (grant_valid)
               state_nx = ACCESS;
         end
         ACCESS: begin
            bus.mem_en = 1'b1;
            bus.mem_we = is_store;
            bus.d_gnt  = (owner == OWN_DATA);
            bus.if_gnt = (owner == OWN_FETCH);
            state_nx   = is_store ? RESP : WAIT;
         end
         WAIT: begin
            if (cnt <= LAT_W'(1))
               state_nx = RESP;
         end
         RESP: begin
            bus.d_valid  = (owner == OWN_DATA);
            bus.if_valid = (owner == OWN_FETCH);
            state_nx     = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Request latching, latency counter and read-data capture.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         owner      <= OWN_FETCH;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt        <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  owner <= winner;
                  if (winner == OWN_DATA) begin
                     addr_q  <= bus.d_addr;
                     we_q    <= bus.d_we;
                     wdata_q <= bus.d_wdata;
                  end else begin
                     addr_q  <= bus.if_addr;
                     we_q    <= 1'b0;
                     wdata_q <= '0;
                  end
               end
            end
            ACCESS: begin
               cnt <= LAT_W'(MEM_LAT);
               if (is_store)
                  d_rdata_q <= '0;
            end
            WAIT: begin
               cnt <= cnt - LAT_W'(1);
               if (cnt == LAT_W'(1)) begin
                  if (owner == OWN_DATA)
                     d_rdata_q <= bus.mem_rdata;
                  else
                     if_rdata_q <= bus.mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
